// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the toy-CPU run controller: host op codes, controller
// states and default geometry of the CPU scan chain.
package cpu_run_ctrl_pkg;

  localparam int SCAN_LEN_DEF       = 19;
  localparam int CPU_RST_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_WRITE  = 3'd1,
    OP_RUN    = 3'd2,
    OP_STEP   = 3'd3,
    OP_STOP   = 3'd4,
    OP_DUMP   = 3'd5,
    OP_CPURST = 3'd6,
    OP_SETPTR = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_CPURST = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_DUMP   = 3'd4
  } state_e;

  // A step count of zero encodes the full sixteen instructions.
  function automatic logic [4:0] stepCount(input logic [3:0] n);
    return (n == 4'd0) ? 5'd16 : {1'b0, n};
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host-side command and dump bus of the run controller; master is the host
// driver, slave is the controller.
interface cpu_run_ctrl_if #(
  parameter int SCAN_LEN = cpu_run_ctrl_pkg::SCAN_LEN_DEF
) ();
  import cpu_run_ctrl_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  op_e                 cmd_op;
  logic [7:0]          cmd_data;
  logic                cmd_err;
  logic                busy;
  logic                dump_valid;
  logic [SCAN_LEN-1:0] dump_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, cmd_err, busy, dump_valid, dump_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, cmd_err, busy, dump_valid, dump_data
  );

endinterface

// File: rtl/cpu_run_ctrl_scan_capture.sv
// Serial-to-parallel capture of the CPU scan chain; the first bit shifted in
// ends up in the MSB, and the result is published with a one-cycle strobe.
module cpu_run_ctrl_scan_capture #(
  parameter int SCAN_LEN = cpu_run_ctrl_pkg::SCAN_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_i,
  input  logic                load_i,
  input  logic                bit_i,
  output logic [SCAN_LEN-1:0] data_o,
  output logic                valid_o
);

  logic [SCAN_LEN-1:0] shift_q;
  logic [SCAN_LEN-1:0] shift_d;
  logic [SCAN_LEN-1:0] data_q;
  logic                valid_q;

  assign shift_d = {shift_q[SCAN_LEN-2:0], bit_i};

  // The load strobe coincides with the last shift, so the published word
  // already contains the final sampled bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_i;
      if (shift_i) shift_q <= shift_d;
      if (load_i)  data_q  <= shift_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 4-bit toy CPU: sequences CPU reset, free-run, stepping
// and scan dumps, and arbitrates the shared 16x8 memory port between host and CPU.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int SCAN_LEN       = SCAN_LEN_DEF,
  parameter int CPU_RST_CYCLES = CPU_RST_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_run_ctrl_if.slave  host,
  output logic           cpu_clk_en_o,
  output logic           cpu_rst_o,
  output logic           cpu_scan_en_o,
  input  logic           cpu_scan_out_i,
  input  logic           cpu_we_i,
  input  logic [3:0]     cpu_addr_i,
  input  logic [7:0]     cpu_wdata_i,
  output logic           mem_we_o,
  output logic [3:0]     mem_addr_o,
  output logic [7:0]     mem_wdata_o
);

  localparam int CNT_MAX0 = (SCAN_LEN > 16) ? SCAN_LEN : 16;
  localparam int CNT_MAX  = (CPU_RST_CYCLES > CNT_MAX0) ? CPU_RST_CYCLES : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         wptr_q, wptr_d;
  logic               cmdErr_q, cmdErr_d;

  logic               clkEn;
  logic               scanEn;
  logic               ready;
  logic               hostWe;
  logic               scanShift;
  logic               scanLoad;
  logic               handshake;
  logic               cpuOwnsPort;
  logic               dumpValid;
  logic [SCAN_LEN-1:0] dumpData;

  assign handshake = host.cmd_valid & host.cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_CPURST;
      cnt_q    <= '0;
      wptr_q   <= 4'd0;
      cmdErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      cmdErr_q <= cmdErr_d;
    end
  end

  // cnt_q is shared: reset hold length, remaining step cycles, or dump cycle index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    cmdErr_d  = 1'b0;
    clkEn     = 1'b0;
    scanEn    = 1'b0;
    ready     = 1'b0;
    hostWe    = 1'b0;
    scanShift = 1'b0;
    scanLoad  = 1'b0;

    case (state_q)
      ST_CPURST: begin
        clkEn = 1'b1;
        if (cnt_q >= CNT_W'(CPU_RST_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        ready = 1'b1;
        if (handshake) begin
          case (host.cmd_op)
            OP_WRITE: begin
              hostWe = 1'b1;
              wptr_d = wptr_q + 4'd1;
            end
            OP_SETPTR: wptr_d = host.cmd_data[3:0];
            OP_RUN:    state_d = ST_RUN;
            OP_STEP: begin
              state_d = ST_STEP;
              cnt_d   = CNT_W'(stepCount(host.cmd_data[3:0]));
            end
            OP_DUMP: begin
              state_d = ST_DUMP;
              cnt_d   = '0;
            end
            OP_CPURST: begin
              state_d = ST_CPURST;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        clkEn = 1'b1;
        ready = 1'b1;
        if (handshake) begin
          if (host.cmd_op == OP_STOP) begin
            state_d = ST_IDLE;
          end else if (host.cmd_op == OP_CPURST) begin
            state_d = ST_CPURST;
            cnt_d   = '0;
          end else begin
            cmdErr_d = 1'b1;
          end
        end
      end

      ST_STEP: begin
        clkEn = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DUMP: begin
        clkEn  = 1'b1;
        scanEn = 1'b1;
        // Cycle 0 lets the CPU capture its state; cycles 1..SCAN_LEN carry bits.
        scanShift = (cnt_q != '0);
        if (cnt_q == CNT_W'(SCAN_LEN)) begin
          scanLoad = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_CPURST;
        cnt_d   = '0;
      end
    endcase
  end

  cpu_run_ctrl_scan_capture #(.SCAN_LEN(SCAN_LEN)) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_i (scanShift),
    .load_i  (scanLoad),
    .bit_i   (cpu_scan_out_i),
    .data_o  (dumpData),
    .valid_o (dumpValid)
  );

  // rst_n gates the visible controls so nothing fires in a reset cycle.
  assign host.cmd_ready  = ready & rst_n;
  assign host.cmd_err    = cmdErr_q & rst_n;
  assign host.busy       = (state_q != ST_IDLE) | ~rst_n;
  assign host.dump_valid = dumpValid & rst_n;
  assign host.dump_data  = dumpData;

  assign cpu_clk_en_o  = clkEn & rst_n;
  assign cpu_rst_o     = (state_q == ST_CPURST) | ~rst_n;
  assign cpu_scan_en_o = scanEn & rst_n;

  assign cpuOwnsPort = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign mem_we_o    = rst_n & (cpuOwnsPort ? cpu_we_i : hostWe);
  assign mem_addr_o  = cpuOwnsPort ? cpu_addr_i  : wptr_q;
  assign mem_wdata_o = cpuOwnsPort ? cpu_wdata_i : host.cmd_data;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a scripted fake CPU, a 16x8 memory and
// a reference memory/pointer model driven from randomized host command sequences.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int SL = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cpuClkEn, cpuRst, cpuScanEn, cpuScanOut, cpuWe;
  logic [3:0]    cpuAddr;
  logic [7:0]    cpuWdata;
  logic          memWe;
  logic [3:0]    memAddr;
  logic [7:0]    memWdata;

  cpu_run_ctrl_if #(.SCAN_LEN(SL)) bus ();

  cpu_run_ctrl #(.SCAN_LEN(SL), .CPU_RST_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host           (bus),
    .cpu_clk_en_o   (cpuClkEn),
    .cpu_rst_o      (cpuRst),
    .cpu_scan_en_o  (cpuScanEn),
    .cpu_scan_out_i (cpuScanOut),
    .cpu_we_i       (cpuWe),
    .cpu_addr_i     (cpuAddr),
    .cpu_wdata_i    (cpuWdata),
    .mem_we_o       (memWe),
    .mem_addr_o     (memAddr),
    .mem_wdata_o    (memWdata)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]    mem    [16];
  logic [7:0]    refMem [16];
  logic [3:0]    refPtr = 4'd0;

  int            enCycles = 0;
  bit            scriptOn = 1'b0;
  int            scriptAt = 0;
  bit            noiseWe  = 1'b0;
  logic [SL-1:0] chain        = '0;
  logic [SL-1:0] chainPattern = '0;
  bit            scanActive   = 1'b0;

  assign cpuWe      = noiseWe | (scriptOn && (enCycles == scriptAt));
  assign cpuScanOut = chain[SL-1];

  // Memory, enabled-cycle counter and a CPU scan chain that captures on the first scan edge.
  always @(posedge clk) begin
    if (memWe) mem[memAddr] <= memWdata;
    if (cpuClkEn) enCycles <= enCycles + 1;
    if (cpuClkEn && cpuScanEn) begin
      if (!scanActive) begin
        chain      <= chainPattern;
        scanActive <= 1'b1;
      end else begin
        chain <= {chain[SL-2:0], 1'b0};
      end
    end else begin
      scanActive <= 1'b0;
    end
  end

  task automatic applyStimulus(input op_e op, input logic [7:0] data, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = 8'h00;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL handshake op=%0d got no ready within 64 cycles, required ready", op);
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cpuRst, cpuClkEn, cpuScanEn, bus.cmd_ready, bus.cmd_err, bus.dump_valid, bus.busy} !== 7'b1000001) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b required 1000001",
               {cpuRst, cpuClkEn, cpuScanEn, bus.cmd_ready, bus.cmd_err, bus.dump_valid, bus.busy});
    end
    checks++;
    if (bus.dump_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dump_data got %h required 0", bus.dump_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cpuClkEn && cpuRst) n++;
      else break;
      @(negedge clk);
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("[TB] FAIL cpurst_cycles got %0d required 2", n);
    end
    checks++;
    if ({bus.cmd_ready, bus.busy, cpuRst, cpuClkEn} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %b required 1000", {bus.cmd_ready, bus.busy, cpuRst, cpuClkEn});
    end
    refPtr = 4'd0;
  endtask

  task automatic test_write_ptr;
    bit ok;
    logic [7:0] d;
    applyStimulus(OP_SETPTR, 8'h00, ok);
    refPtr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      applyStimulus(OP_WRITE, d, ok);
      refMem[refPtr] = d;
      refPtr = refPtr + 4'd1;
    end
    applyStimulus(OP_SETPTR, 8'hF0 | 8'd15, ok);
    refPtr = 4'd15;
    applyStimulus(OP_WRITE, 8'hA1, ok);
    refMem[refPtr] = 8'hA1; refPtr = refPtr + 4'd1;
    applyStimulus(OP_WRITE, 8'hB2, ok);
    refMem[refPtr] = 8'hB2; refPtr = refPtr + 4'd1;
    #1;
    checks++;
    if (mem[15] !== 8'hA1 || mem[0] !== 8'hB2) begin
      errors++;
      $display("[TB] FAIL ptr_wrap got mem15=%h mem0=%h required A1 B2", mem[15], mem[0]);
    end
    checks++;
    if (memAddr !== 4'd1) begin
      errors++;
      $display("[TB] FAIL wptr_after_wrap got %0d required 1", memAddr);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (mem[a] !== refMem[a]) begin
        errors++;
        $display("[TB] FAIL fill_mem[%0d] got %h required %h", a, mem[a], refMem[a]);
      end
    end
  endtask

  task automatic test_idle_ops;
    bit ok;
    op_e op;
    logic [7:0] d;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_NOP;
        1: op = OP_STOP;
        2: op = OP_SETPTR;
        default: op = OP_WRITE;
      endcase
      d = 8'($urandom);
      applyStimulus(op, d, ok);
      if (op == OP_WRITE) begin
        refMem[refPtr] = d;
        refPtr = refPtr + 4'd1;
      end else if (op == OP_SETPTR) begin
        refPtr = d[3:0];
      end
      #1;
      checks++;
      if (bus.cmd_err !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_op%0d err/busy got %b%b required 00", op, bus.cmd_err, bus.busy);
      end
    end
    checks++;
    if (memAddr !== refPtr) begin
      errors++;
      $display("[TB] FAIL idle_wptr got %0d required %0d", memAddr, refPtr);
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (mem[a] !== refMem[a]) begin
        errors++;
        $display("[TB] FAIL idle_mem[%0d] got %h required %h", a, mem[a], refMem[a]);
      end
    end
  endtask

  task automatic test_step;
    bit ok;
    int base, w, n, want;
    cpuAddr  = 4'd9;
    cpuWdata = 8'h80;
    base     = enCycles;
    scriptAt = base + 2;
    scriptOn = 1'b1;
    applyStimulus(OP_STEP, 8'h03, ok);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || cpuClkEn !== 1'b1) begin
      errors++;
      $display("[TB] FAIL step_active ready/busy/en got %b%b%b required 011", bus.cmd_ready, bus.busy, cpuClkEn);
    end
    for (w = 0; w < 40; w++) begin
      if (bus.busy === 1'b0) break;
      @(negedge clk); #1;
    end
    scriptOn = 1'b0;
    refMem[9] = 8'h80;
    checks++;
    if (enCycles - base != 3 || w == 40) begin
      errors++;
      $display("[TB] FAIL step3_cycles got %0d required 3", enCycles - base);
    end
    checks++;
    if (mem[9] !== 8'h80) begin
      errors++;
      $display("[TB] FAIL step3_sta got %h required 80", mem[9]);
    end
    for (int k = 0; k < 3; k++) begin
      n    = (k == 0) ? 0 : $urandom_range(1, 15);
      want = (n == 0) ? 16 : n;
      base = enCycles;
      applyStimulus(OP_STEP, 8'(n) | 8'hA0, ok);
      #1;
      for (w = 0; w < 40; w++) begin
        if (bus.busy === 1'b0) break;
        @(negedge clk); #1;
      end
      checks++;
      if (enCycles - base != want || w == 40) begin
        errors++;
        $display("[TB] FAIL step%0d_cycles got %0d required %0d", n, enCycles - base, want);
      end
    end
  endtask

  task automatic test_run_stop;
    bit ok;
    int base;
    logic [3:0] a;
    logic [7:0] d;
    a = 4'($urandom);
    d = 8'($urandom);
    cpuAddr  = a;
    cpuWdata = d;
    base     = enCycles;
    scriptAt = base + 3;
    scriptOn = 1'b1;
    applyStimulus(OP_RUN, 8'h00, ok);
    repeat (6) @(negedge clk);
    scriptOn = 1'b0;
    refMem[a] = d;
    #1;
    checks++;
    if ({cpuClkEn, bus.busy, bus.cmd_ready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL run_active got %b required 111", {cpuClkEn, bus.busy, bus.cmd_ready});
    end
    applyStimulus(OP_WRITE, 8'h5A, ok);
    #1;
    checks++;
    if (bus.cmd_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_write_err got %b required 1", bus.cmd_err);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.cmd_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_err_pulse got %b required 0", bus.cmd_err);
    end
    applyStimulus(OP_STOP, 8'h00, ok);
    #1;
    checks++;
    if (cpuClkEn !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop got en=%b busy=%b required 0 0", cpuClkEn, bus.busy);
    end
    cpuAddr  = 4'($urandom);
    cpuWdata = 8'($urandom);
    noiseWe  = 1'b1;
    repeat (5) @(negedge clk);
    noiseWe  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== refMem[i]) begin
        errors++;
        $display("[TB] FAIL run_mem[%0d] got %h required %h", i, mem[i], refMem[i]);
      end
    end
  endtask

  task automatic test_dump;
    bit ok;
    int scanCnt, validCnt, validAt;
    logic [SL-1:0] got;
    for (int k = 0; k < 3; k++) begin
      chainPattern = (k == 0) ? SL'(20'h5A3C1) : SL'($urandom);
      cpuAddr  = 4'($urandom);
      cpuWdata = 8'($urandom);
      noiseWe  = 1'b1;
      scanCnt  = 0; validCnt = 0; validAt = -1; got = '0;
      applyStimulus(OP_DUMP, 8'h00, ok);
      #1;
      for (int i = 0; i < 40; i++) begin
        if (cpuScanEn === 1'b1) scanCnt++;
        if (bus.dump_valid === 1'b1) begin
          validCnt++;
          validAt = i;
          got = bus.dump_data;
        end
        @(negedge clk); #1;
      end
      noiseWe = 1'b0;
      checks++;
      if (scanCnt != SL + 1 || validCnt != 1 || validAt != SL + 1) begin
        errors++;
        $display("[TB] FAIL dump_timing got scan=%0d valid=%0d at=%0d required %0d 1 %0d",
                 scanCnt, validCnt, validAt, SL + 1, SL + 1);
      end
      checks++;
      if (got !== chainPattern || bus.dump_data !== chainPattern) begin
        errors++;
        $display("[TB] FAIL dump_data got %h required %h", got, chainPattern);
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== refMem[i]) begin
        errors++;
        $display("[TB] FAIL dump_mem[%0d] got %h required %h", i, mem[i], refMem[i]);
      end
    end
  endtask

  task automatic test_dump_abort;
    bit ok;
    int validCnt, n;
    chainPattern = SL'($urandom) | SL'(1);
    validCnt = 0;
    applyStimulus(OP_DUMP, 8'h00, ok);
    repeat (7) begin
      #1;
      if (bus.dump_valid === 1'b1) validCnt++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpuClkEn, cpuScanEn, bus.dump_valid, bus.cmd_err, cpuRst, bus.busy} !== 6'b000011) begin
      errors++;
      $display("[TB] FAIL abort_cycle got %b required 000011",
               {cpuClkEn, cpuScanEn, bus.dump_valid, bus.cmd_err, cpuRst, bus.busy});
    end
    @(negedge clk);
    rst_n  = 1'b1;
    refPtr = 4'd0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.dump_valid === 1'b1) validCnt++;
      if (cpuClkEn && cpuRst) n++;
      else break;
      @(negedge clk);
    end
    repeat (25) begin
      #1;
      if (bus.dump_valid === 1'b1) validCnt++;
      @(negedge clk);
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("[TB] FAIL abort_cpurst got %0d required 2", n);
    end
    checks++;
    if (validCnt != 0 || bus.dump_data !== '0) begin
      errors++;
      $display("[TB] FAIL abort_dump got valid=%0d data=%h required 0 0", validCnt, bus.dump_data);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int base, n;
    logic [7:0] d;
    logic [3:0] at;
    d    = 8'($urandom);
    at   = refPtr;
    base = enCycles;
    applyStimulus(OP_STEP, 8'h04, ok);
    applyStimulus(OP_WRITE, d, ok);
    refMem[at] = d;
    refPtr = refPtr + 4'd1;
    #1;
    checks++;
    if (mem[at] !== d || enCycles - base != 4) begin
      errors++;
      $display("[TB] FAIL held_write got mem=%h en=%0d required %h 4", mem[at], enCycles - base, d);
    end
    applyStimulus(OP_CPURST, 8'h00, ok);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cpuClkEn && cpuRst) n++;
      else break;
      @(negedge clk);
    end
    checks++;
    if (n != 2 || memAddr !== refPtr || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL host_cpurst got cycles=%0d wptr=%0d busy=%b required 2 %0d 0",
               n, memAddr, bus.busy, refPtr);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = 8'h00;
    cpuAddr       = 4'd0;
    cpuWdata      = 8'h00;
    test_reset;
    test_write_ptr;
    test_idle_ops;
    test_step;
    test_run_stop;
    test_dump;
    test_dump_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no completion required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
